// File: rtl/uart_rx_framed.sv
// uart_rx_framed: parametrised UART receive engine.
//   Takes the asynchronous serial line and synchronises it. It finds the start bit and
//   samples every bit at mid-bit with an internal baud counter. Parity is optional and
//   one or two stop bits are checked. Each frame is delivered through a one-entry
//   valid/ready holding register.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-low
//   rx          serial line, asynchronous, idle high
//   ready       consumer accepts the held frame this cycle
//   valid       held frame present
//   result      received payload, LSB first on the line
//   parity_err  parity mismatch in held frame (0 when parity disabled)
//   frame_err   a stop bit was sampled low in held frame
//   overrun     1-cycle pulse: frame finished while holding register full and not drained
//   busy        receiver is inside a frame (state != IDLE)

`timescale 1ns/1ps

module uart_rx_framed #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_BITS-1:0] result,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = 1'(PARITY_ODD);
    localparam logic          PAR_EN    = 1'(PARITY_EN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state;
    logic                   rx_meta;
    logic                   rx_s;
    logic                   armed;
    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic                   stop_idx;
    logic [DATA_BITS-1:0]   shift;
    logic                   perr;
    logic                   ferr;
    logic                   done;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Receive FSM with baud counter; done pulses the cycle after the last stop sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            armed    <= 1'b0;
            cnt      <= '0;
            idx      <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            perr     <= 1'b0;
            ferr     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    // A low line only starts a frame once the line has been seen high.
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= S_START;
                        busy  <= 1'b1;
                        armed <= 1'b0;
                        perr  <= 1'b0;
                        ferr  <= 1'b0;
                    end
                end

                S_START: begin
                    if (cnt == CNT_MID) begin
                        cnt <= '0;
                        if (rx_s) begin
                            // Line back high at mid start bit: glitch, not a frame.
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DATA;
                            idx   <= '0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        // LSB arrives first, so shifting in at the top leaves it at bit 0.
                        shift <= {rx_s, shift[DATA_BITS-1:1]};
                        if (idx == IDX_LAST) begin
                            stop_idx <= 1'b0;
                            state    <= PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_PARITY: begin
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        perr  <= ((^shift) ^ rx_s) != PAR_ODD;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt  <= '0;
                        ferr <= ferr | ~rx_s;
                        if (stop_idx == STOP_LAST) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // One-entry holding register; a finished frame loads if the slot is free or draining.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid      <= 1'b0;
            result     <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done && (!valid || ready)) begin
                valid      <= 1'b1;
                result     <= shift;
                parity_err <= perr;
                frame_err  <= ferr;
            end else begin
                if (done) begin
                    overrun <= 1'b1;
                end
                if (valid && ready) begin
                    valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
`timescale 1ns/1ps

module tb_uart_rx_framed;

    localparam int unsigned CPB = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx, rx_p;
    logic       ready, ready_p;

    logic       valid, parity_err, frame_err, overrun, busy;
    logic [7:0] result;
    logic       valid_p, parity_err_p, frame_err_p, overrun_p, busy_p;
    logic [7:0] result_p;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;

    // Capture of the most recent delivered frame per instance.
    int         vcount = 0, pvcount = 0, ov_count = 0;
    int         cap_cyc = 0;
    logic [7:0] cap_res = '0, pcap_res = '0;
    logic       cap_pe = 1'b0, cap_fe = 1'b0, pcap_pe = 1'b0, pcap_fe = 1'b0;
    logic       valid_q = 1'b0, valid_pq = 1'b0;

    int v0, pv0, o0, lat;

    uart_rx_framed #(
        .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut (
        .clk(clk), .rst(rst), .rx(rx), .ready(ready),
        .valid(valid), .result(result), .parity_err(parity_err),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    uart_rx_framed #(
        .DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)
    ) dut_p (
        .clk(clk), .rst(rst), .rx(rx_p), .ready(ready_p),
        .valid(valid_p), .result(result_p), .parity_err(parity_err_p),
        .frame_err(frame_err_p), .overrun(overrun_p), .busy(busy_p)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid && !valid_q) begin
            cap_res = result;
            cap_pe  = parity_err;
            cap_fe  = frame_err;
            cap_cyc = cyc;
            vcount++;
        end
        valid_q = valid;
        if (overrun) ov_count++;
        if (valid_p && !valid_pq) begin
            pcap_res = result_p;
            pcap_pe  = parity_err_p;
            pcap_fe  = frame_err_p;
            pvcount++;
        end
        valid_pq = valid_p;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx   = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards.
    task automatic send(input bit sel, input logic [7:0] d, input bit has_par,
                        input logic par, input logic stopv);
        start_cyc = cyc;
        set_line(sel, 1'b0);
        hold(CPB);
        for (int i = 0; i < 8; i++) begin
            set_line(sel, d[i]);
            hold(CPB);
        end
        if (has_par) begin
            set_line(sel, par);
            hold(CPB);
        end
        set_line(sel, stopv);
        hold(CPB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rx = 1'b1; rx_p = 1'b1; ready = 1'b1; ready_p = 1'b1;
        hold(3);
        check("rst_valid",      32'(valid),      32'd0);
        check("rst_result",     32'(result),     32'd0);
        check("rst_parity_err", 32'(parity_err), 32'd0);
        check("rst_frame_err",  32'(frame_err),  32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        rst = 1'b1;
        hold(5);

        // 1: clean 0xA5, 8N1
        v0 = vcount;
        send(0, 8'hA5, 0, 1'b0, 1'b1);
        lat = cap_cyc - start_cyc;
        check("t1_count",  32'(vcount - v0), 32'd1);
        check("t1_result", 32'(cap_res), 32'hA5);
        check("t1_perr",   32'(cap_pe),  32'd0);
        check("t1_ferr",   32'(cap_fe),  32'd0);
        check("t1_latency_window", 32'(lat >= 154 && lat <= 157), 32'd1);
        check("t1_valid_dropped", 32'(valid), 32'd0);
        hold(CPB);

        // 2: 5-cycle glitch while idle
        v0 = vcount;
        rx = 1'b0;
        hold(5);
        rx = 1'b1;
        hold(20);
        check("t2_busy_idle", 32'(busy), 32'd0);
        check("t2_no_frame",  32'(vcount - v0), 32'd0);

        // 3: even parity on second instance
        pv0 = pvcount;
        send(1, 8'h03, 1, 1'b0, 1'b1);
        check("t3_good_result", 32'(pcap_res), 32'h03);
        check("t3_good_perr",   32'(pcap_pe),  32'd0);
        check("t3_good_ferr",   32'(pcap_fe),  32'd0);
        send(1, 8'h03, 1, 1'b1, 1'b1);
        check("t3_bad_result", 32'(pcap_res), 32'h03);
        check("t3_bad_perr",   32'(pcap_pe),  32'd1);
        check("t3_count",      32'(pvcount - pv0), 32'd2);
        hold(CPB);

        // 4: stop bit low, line held low afterwards
        v0 = vcount;
        send(0, 8'h5A, 0, 1'b0, 1'b0);
        check("t4_ferr",   32'(cap_fe),  32'd1);
        check("t4_result", 32'(cap_res), 32'h5A);
        check("t4_perr",   32'(cap_pe),  32'd0);
        hold(3 * CPB);
        check("t4_busy_low_line", 32'(busy), 32'd0);
        check("t4_one_frame",     32'(vcount - v0), 32'd1);
        rx = 1'b1;
        hold(2 * CPB);

        // 5: overrun with ready low, back-to-back frames
        ready = 1'b0;
        v0 = vcount;
        o0 = ov_count;
        send(0, 8'h11, 0, 1'b0, 1'b1);
        send(0, 8'h22, 0, 1'b0, 1'b1);
        check("t5_held_result", 32'(result), 32'h11);
        check("t5_held_valid",  32'(valid),  32'd1);
        check("t5_overrun_once", 32'(ov_count - o0), 32'd1);
        check("t5_one_delivery", 32'(vcount - v0), 32'd1);
        ready = 1'b1;
        hold(1);
        check("t5_valid_drop", 32'(valid), 32'd0);
        hold(CPB);

        // 6: reset mid-DATA of 0xFF
        rx = 1'b0;
        hold(CPB);
        rx = 1'b1;
        hold(3 * CPB);
        check("t6_busy_mid", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid), 32'd0);
        check("t6_rst_busy",  32'(busy),  32'd0);
        hold(2);
        rst = 1'b1;
        hold(2 * CPB);
        check("t6_no_partial", 32'(valid), 32'd0);
        v0 = vcount;
        send(0, 8'h3C, 0, 1'b0, 1'b1);
        check("t6_result", 32'(cap_res), 32'h3C);
        check("t6_ferr",   32'(cap_fe),  32'd0);
        check("t6_count",  32'(vcount - v0), 32'd1);
        hold(CPB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
